// File: rtl/logic_pkg.sv
// Shared definitions for the logic_* stream primitives: target selection
// and the occupancy-counter width helper used by the queue and the stack.
package logic_pkg;

  typedef enum logic [1:0] {
    TARGET_GENERIC,
    TARGET_XILINX,
    TARGET_INTEL
  } target_t;

  // Bits needed to hold the values 0..value inclusive (occupancy counters).
  function automatic int clog2_plus1(input int value);
    return $clog2(value + 1);
  endfunction

endpackage

// File: rtl/logic_basic_stack_main.sv
// LIFO core: storage, occupancy count and rx/tx valid-ready handshake.
// Optional level output under LOGIC_BASIC_STACK_LEVEL_EN.
module logic_basic_stack_main
  import logic_pkg::*;
#(
  parameter target_t TARGET   = TARGET_GENERIC,
  parameter int      CAPACITY = 16,
  parameter int      WIDTH    = 1
) (
  input  logic                              aclk,
  input  logic                              areset_n,
  input  logic                              rx_tvalid,
  input  logic [WIDTH-1:0]                  rx_tdata,
  output logic                              rx_tready,
  input  logic                              tx_tready,
  output logic                              tx_tvalid,
  output logic [WIDTH-1:0]                  tx_tdata
`ifdef LOGIC_BASIC_STACK_LEVEL_EN
  ,
  output logic [clog2_plus1(CAPACITY)-1:0]  level
`endif
);

  localparam int CW    = clog2_plus1(CAPACITY);
  localparam int AW    = $clog2(CAPACITY);
  localparam int DEPTH = 2 ** AW;

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [CW-1:0] count_dec;
  logic          ready;
  logic          push;
  logic          pop;
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;

  assign push      = rx_tvalid & ready;
  assign pop       = tx_tvalid & tx_tready;
  assign count_dec = count - CW'(1);
  assign top_idx   = count_dec[AW-1:0];
  // Simultaneous push and pop overwrites the current top in place.
  assign wr_idx    = pop ? top_idx : count[AW-1:0];

  assign rx_tready = ready;
  assign tx_tvalid = (count != '0);

  // Next occupancy; a push only lands when ready, a pop only when valid,
  // so the counter can neither wrap nor underflow.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count_dec;
      default: count_next = count;
    endcase
  end

  // Occupancy and registered ready; ready depends on count only, so no
  // combinational path exists from tx_tready.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      count <= '0;
      ready <= 1'b0;
    end else begin
      count <= count_next;
      ready <= (count_next != CW'(CAPACITY));
    end
  end

  generate
    if (TARGET == TARGET_GENERIC) begin : g_reg_store
      logic [WIDTH-1:0] mem [DEPTH];

      // Register storage, never cleared; tx_tdata is don't-care when empty.
      always_ff @(posedge aclk) begin
        if (push) mem[wr_idx] <= rx_tdata;
      end

      assign tx_tdata = mem[top_idx];
    end else begin : g_dist_store
      (* ram_style = "distributed" *)
      logic [WIDTH-1:0] mem [DEPTH];

      // Distributed RAM storage with asynchronous read of the top entry.
      always_ff @(posedge aclk) begin
        if (push) mem[wr_idx] <= rx_tdata;
      end

      assign tx_tdata = mem[top_idx];
    end
  endgenerate

`ifdef LOGIC_BASIC_STACK_LEVEL_EN
  assign level = count;
`endif

endmodule

// File: rtl/logic_reset_synchronizer.sv
// Reset synchronizer: asserts asynchronously, releases synchronously after
// STAGES rising edges of aclk.
module logic_reset_synchronizer #(
  parameter int STAGES = 2
) (
  input  logic aclk,
  input  logic areset_n,
  output logic reset_n
);

  logic [STAGES-1:0] sync;

  // Shift ones in after release; clear the whole chain on assertion.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      sync <= '0;
    end else begin
      sync <= {sync[STAGES-2:0], 1'b1};
    end
  end

  assign reset_n = sync[STAGES-1];

endmodule

// File: rtl/logic_basic_stack.sv
// LIFO stack top: synchronizes reset release and wraps the core.
// Optional level output under LOGIC_BASIC_STACK_LEVEL_EN.
module logic_basic_stack
  import logic_pkg::*;
#(
  parameter target_t TARGET   = TARGET_GENERIC,
  parameter int      CAPACITY = 16,
  parameter int      WIDTH    = 1
) (
  input  logic                              aclk,
  input  logic                              areset_n,
  input  logic                              rx_tvalid,
  input  logic [WIDTH-1:0]                  rx_tdata,
  output logic                              rx_tready,
  input  logic                              tx_tready,
  output logic                              tx_tvalid,
  output logic [WIDTH-1:0]                  tx_tdata
`ifdef LOGIC_BASIC_STACK_LEVEL_EN
  ,
  output logic [clog2_plus1(CAPACITY)-1:0]  level
`endif
);

  logic reset_n;

  logic_reset_synchronizer #(
    .STAGES(2)
  ) u_reset_sync (
    .aclk    (aclk),
    .areset_n(areset_n),
    .reset_n (reset_n)
  );

  logic_basic_stack_main #(
    .TARGET  (TARGET),
    .CAPACITY(CAPACITY),
    .WIDTH   (WIDTH)
  ) u_main (
    .aclk     (aclk),
    .areset_n (reset_n),
    .rx_tvalid(rx_tvalid),
    .rx_tdata (rx_tdata),
    .rx_tready(rx_tready),
    .tx_tready(tx_tready),
    .tx_tvalid(tx_tvalid),
    .tx_tdata (tx_tdata)
`ifdef LOGIC_BASIC_STACK_LEVEL_EN
    ,
    .level    (level)
`endif
  );

endmodule

// File: tb/tb_logic_basic_stack.sv
// Testbench for logic_basic_stack (CAPACITY=4, WIDTH=8): directed vector
// table, reset-in-flight sequence and randomized traffic against a LIFO model.
module tb_logic_basic_stack;
  import logic_pkg::*;

  localparam int CAP = 4;
  localparam int W   = 8;

  logic         aclk      = 1'b0;
  logic         areset_n  = 1'b0;
  logic         rx_tvalid = 1'b0;
  logic [W-1:0] rx_tdata  = '0;
  logic         tx_tready = 1'b0;
  logic         rx_tready;
  logic         tx_tvalid;
  logic [W-1:0] tx_tdata;
`ifdef LOGIC_BASIC_STACK_LEVEL_EN
  logic [2:0]   level;
`endif

  logic_basic_stack #(
    .TARGET  (TARGET_GENERIC),
    .CAPACITY(CAP),
    .WIDTH   (W)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .rx_tvalid(rx_tvalid),
    .rx_tdata (rx_tdata),
    .rx_tready(rx_tready),
    .tx_tready(tx_tready),
    .tx_tvalid(tx_tvalid),
    .tx_tdata (tx_tdata)
`ifdef LOGIC_BASIC_STACK_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  always #5 aclk = ~aclk;

  int n_pass  = 0;
  int n_total = 0;

  logic [W-1:0] model [$];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         r;
    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic         exp_ready;
  } vec_t;

  vec_t vecs [27];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Apply inputs for one cycle and stop at the falling edge to sample.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic r);
    rx_tvalid = v;
    rx_tdata  = d;
    tx_tready = r;
    @(negedge aclk);
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  // Bounded wait for rx_tready after a reset release.
  task automatic wait_ready(input string tag);
    int k = 0;
    while (k < 10 && rx_tready !== 1'b1) begin
      next_cycle();
      k++;
    end
    check({tag, "_ready_after_release"}, 32'(rx_tready), 32'(1));
    check({tag, "_valid_after_release"}, 32'(tx_tvalid), 32'(0));
  endtask

  // One cycle checked against the LIFO reference model.
  task automatic model_cycle(input logic v, input logic [W-1:0] d, input logic r,
                             input string tag);
    logic ev;
    logic er;
    ev = (model.size() != 0);
    er = (model.size() != CAP);
    drive(v, d, r);
    check({tag, "_valid"}, 32'(tx_tvalid), 32'(ev));
    check({tag, "_ready"}, 32'(rx_tready), 32'(er));
    if (ev) check({tag, "_data"}, 32'(tx_tdata), 32'(model[$]));
`ifdef LOGIC_BASIC_STACK_LEVEL_EN
    check({tag, "_level"}, 32'(level), 32'(model.size()));
`endif
    if (ev && r) void'(model.pop_back());
    if (v && er) model.push_back(d);
    next_cycle();
  endtask

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic r,
                              input logic ev, input logic [W-1:0] ed, input logic er);
    vec_t t;
    t.v = v; t.d = d; t.r = r;
    t.exp_valid = ev; t.exp_data = ed; t.exp_ready = er;
    return t;
  endfunction

  initial begin
    // Push 11,22,33 then pop three times.
    vecs[0]  = mk(1, 8'h11, 0, 0, 8'h00, 1);
    vecs[1]  = mk(1, 8'h22, 0, 1, 8'h11, 1);
    vecs[2]  = mk(1, 8'h33, 0, 1, 8'h22, 1);
    vecs[3]  = mk(0, 8'h00, 1, 1, 8'h33, 1);
    vecs[4]  = mk(0, 8'h00, 1, 1, 8'h22, 1);
    vecs[5]  = mk(0, 8'h00, 1, 1, 8'h11, 1);
    vecs[6]  = mk(0, 8'h00, 0, 0, 8'h00, 1);
    // Fill with A0..A3, hold A4 while full, pop frees one slot.
    vecs[7]  = mk(1, 8'hA0, 0, 0, 8'h00, 1);
    vecs[8]  = mk(1, 8'hA1, 0, 1, 8'hA0, 1);
    vecs[9]  = mk(1, 8'hA2, 0, 1, 8'hA1, 1);
    vecs[10] = mk(1, 8'hA3, 0, 1, 8'hA2, 1);
    vecs[11] = mk(1, 8'hA4, 0, 1, 8'hA3, 0);
    vecs[12] = mk(1, 8'hA4, 0, 1, 8'hA3, 0);
    vecs[13] = mk(1, 8'hA4, 1, 1, 8'hA3, 0);
    vecs[14] = mk(1, 8'hA4, 0, 1, 8'hA2, 1);
    vecs[15] = mk(0, 8'h00, 1, 1, 8'hA4, 0);
    vecs[16] = mk(0, 8'h00, 1, 1, 8'hA2, 1);
    vecs[17] = mk(0, 8'h00, 1, 1, 8'hA1, 1);
    vecs[18] = mk(0, 8'h00, 1, 1, 8'hA0, 1);
    // Hold 01,02; simultaneous push 55 / pop 02.
    vecs[19] = mk(1, 8'h01, 0, 0, 8'h00, 1);
    vecs[20] = mk(1, 8'h02, 0, 1, 8'h01, 1);
    vecs[21] = mk(1, 8'h55, 1, 1, 8'h02, 1);
    vecs[22] = mk(0, 8'h00, 1, 1, 8'h55, 1);
    vecs[23] = mk(0, 8'h00, 1, 1, 8'h01, 1);
    // Push into empty with tx_tready=1: no bypass.
    vecs[24] = mk(1, 8'h7E, 1, 0, 8'h00, 1);
    vecs[25] = mk(0, 8'h00, 1, 1, 8'h7E, 1);
    vecs[26] = mk(0, 8'h00, 0, 0, 8'h00, 1);

    // Reset state.
    repeat (3) @(posedge aclk);
    #1;
    check("reset_valid", 32'(tx_tvalid), 32'(0));
    check("reset_ready", 32'(rx_tready), 32'(0));
`ifdef LOGIC_BASIC_STACK_LEVEL_EN
    check("reset_level", 32'(level), 32'(0));
`endif
    areset_n = 1'b1;
    wait_ready("init");

    // Directed vector table.
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].d, vecs[i].r);
      check($sformatf("vec%0d_valid", i), 32'(tx_tvalid), 32'(vecs[i].exp_valid));
      check($sformatf("vec%0d_ready", i), 32'(rx_tready), 32'(vecs[i].exp_ready));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_data", i), 32'(tx_tdata), 32'(vecs[i].exp_data));
      next_cycle();
    end

    // Reset in flight with three entries stored.
    model.delete();
    model_cycle(1, 8'hC1, 0, "rst_fill0");
    model_cycle(1, 8'hC2, 0, "rst_fill1");
    model_cycle(1, 8'hC3, 0, "rst_fill2");
    rx_tvalid = 1'b0;
    tx_tready = 1'b0;
    #1 areset_n = 1'b0;
    #1;
    check("midreset_valid", 32'(tx_tvalid), 32'(0));
    check("midreset_ready", 32'(rx_tready), 32'(0));
    repeat (2) next_cycle();
    check("midreset_hold_valid", 32'(tx_tvalid), 32'(0));
    areset_n = 1'b1;
    model.delete();
    wait_ready("midreset");

    // Randomized traffic against the reference LIFO.
    begin
      logic         hold_v;
      logic [W-1:0] hold_d;
      logic         pending;
      logic         v;
      logic [W-1:0] d;
      logic         r;
      pending = 1'b0;
      hold_v  = 1'b0;
      hold_d  = '0;
      for (int unsigned i = 0; i < 1000; i++) begin
        if (pending) begin
          v = hold_v;
          d = hold_d;
        end else begin
          v = ($urandom_range(0, 3) != 0);
          d = W'($urandom);
        end
        // Alternate push-heavy and pop-heavy phases to reach full and empty.
        if (((i / 60) % 2) == 0) r = ($urandom_range(0, 3) == 0);
        else                     r = ($urandom_range(0, 3) != 0);
        pending = v && (model.size() == CAP);
        hold_v  = v;
        hold_d  = d;
        model_cycle(v, d, r, "rand");
      end
    end

    rx_tvalid = 1'b0;
    tx_tready = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
